// File: rtl/bit_count_pkg.sv
// Shared definitions for the pipelined bit counter: mode encoding and chunk math.
package bit_count_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_ONES  = 2'b00;
    localparam mode_t MODE_ZEROS = 2'b01;
    localparam mode_t MODE_LZ    = 2'b10;
    localparam mode_t MODE_TZ    = 2'b11;

    // Number of stage-1 chunks; the most significant chunk may be partial.
    function automatic int chunk_count(input int input_width, input int chunk_width);
        return (input_width + chunk_width - 1) / chunk_width;
    endfunction

endpackage

// File: rtl/bit_count_chunk.sv
// Combinational statistics for one chunk: ones count, leading/trailing zeros, all-zero flag.
module bit_count_chunk #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0]     data,
    output logic [CNT_WIDTH-1:0] ones,
    output logic [CNT_WIDTH-1:0] lz,
    output logic [CNT_WIDTH-1:0] tz,
    output logic                 zero
);

    always_comb begin
        ones = '0;
        lz   = CNT_WIDTH'(WIDTH);
        tz   = CNT_WIDTH'(WIDTH);
        // Ascending scan: the last set bit seen is the most significant one.
        for (int i = 0; i < WIDTH; i++) begin
            if (data[i]) begin
                ones = ones + CNT_WIDTH'(1);
                lz   = CNT_WIDTH'(WIDTH - 1 - i);
            end
        end
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (data[i]) begin
                tz = CNT_WIDTH'(i);
            end
        end
        zero = ~|data;
    end

endmodule

// File: rtl/bit_count_pipe.sv
// Two-stage pipelined ones/zeros/LZ/TZ counter with valid/ready backpressure.
// Optional saturating accumulator of transferred counts under BIT_COUNT_ACCUM_EN.
module bit_count_pipe
    import bit_count_pkg::*;
#(
    parameter int INPUT_WIDTH = 32,
    parameter int CHUNK_WIDTH = 8,
    parameter int COUNT_WIDTH = $clog2(INPUT_WIDTH + 1),
    parameter int ACC_WIDTH   = 16
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   InValid,
    output logic                   InReady,
    input  logic [1:0]             Mode,
    input  logic [INPUT_WIDTH-1:0] Input,
    output logic                   OutValid,
    input  logic                   OutReady,
    output logic [COUNT_WIDTH-1:0] Count,
`ifdef BIT_COUNT_ACCUM_EN
    input  logic                   AccClr,
    output logic [ACC_WIDTH-1:0]   AccTotal,
`endif
    output logic                   AllZero
);

    localparam int NUM_CHUNKS   = chunk_count(INPUT_WIDTH, CHUNK_WIDTH);
    localparam int CH_CNT_WIDTH = $clog2(CHUNK_WIDTH + 1);

    // Handshake: a word moves between stages only when the sender holds valid
    // and the receiver is ready at the same rising edge; a held word never changes.
    logic s2_load;
    logic in_fire;
    logic v1;

    assign s2_load = !OutValid || OutReady;
    assign InReady = !v1 || s2_load;
    assign in_fire = InValid && InReady;

    logic [CH_CNT_WIDTH-1:0] c_ones [NUM_CHUNKS];
    logic [CH_CNT_WIDTH-1:0] c_lz   [NUM_CHUNKS];
    logic [CH_CNT_WIDTH-1:0] c_tz   [NUM_CHUNKS];
    logic [NUM_CHUNKS-1:0]   c_zero;

    for (genvar g = 0; g < NUM_CHUNKS; g++) begin : g_chunk
        localparam int LO = g * CHUNK_WIDTH;
        localparam int W  = (LO + CHUNK_WIDTH > INPUT_WIDTH) ? (INPUT_WIDTH - LO) : CHUNK_WIDTH;

        bit_count_chunk #(
            .WIDTH     (W),
            .CNT_WIDTH (CH_CNT_WIDTH)
        ) u_chunk (
            .data (Input[LO +: W]),
            .ones (c_ones[g]),
            .lz   (c_lz[g]),
            .tz   (c_tz[g]),
            .zero (c_zero[g])
        );
    end

    // Stage 1
    mode_t                   s1_mode;
    logic [CH_CNT_WIDTH-1:0] s1_ones [NUM_CHUNKS];
    logic [CH_CNT_WIDTH-1:0] s1_lz   [NUM_CHUNKS];
    logic [CH_CNT_WIDTH-1:0] s1_tz   [NUM_CHUNKS];
    logic [NUM_CHUNKS-1:0]   s1_zero;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            v1 <= 1'b0;
        end else if (InReady) begin
            v1 <= InValid;
        end
    end

    always_ff @(posedge CLK) begin
        if (in_fire) begin
            s1_mode <= mode_t'(Mode);
            s1_zero <= c_zero;
            for (int i = 0; i < NUM_CHUNKS; i++) begin
                s1_ones[i] <= c_ones[i];
                s1_lz[i]   <= c_lz[i];
                s1_tz[i]   <= c_tz[i];
            end
        end
    end

    // Stage 2 combine. A zero chunk reports lz/tz equal to its own width, so summing
    // up to and including the first nonzero chunk gives the word-level LZ/TZ.
    logic [COUNT_WIDTH-1:0] sum_ones;
    logic [COUNT_WIDTH-1:0] sum_zeros;
    logic [COUNT_WIDTH-1:0] sum_lz;
    logic [COUNT_WIDTH-1:0] sum_tz;
    logic [COUNT_WIDTH-1:0] result;
    logic                   lz_done;
    logic                   tz_done;
    logic                   all_zero;

    always_comb begin
        sum_ones = '0;
        sum_lz   = '0;
        sum_tz   = '0;
        lz_done  = 1'b0;
        tz_done  = 1'b0;
        for (int i = 0; i < NUM_CHUNKS; i++) begin
            sum_ones = sum_ones + COUNT_WIDTH'(s1_ones[i]);
        end
        for (int i = NUM_CHUNKS - 1; i >= 0; i--) begin
            if (!lz_done) begin
                sum_lz  = sum_lz + COUNT_WIDTH'(s1_lz[i]);
                lz_done = !s1_zero[i];
            end
        end
        for (int i = 0; i < NUM_CHUNKS; i++) begin
            if (!tz_done) begin
                sum_tz  = sum_tz + COUNT_WIDTH'(s1_tz[i]);
                tz_done = !s1_zero[i];
            end
        end
        sum_zeros = COUNT_WIDTH'(INPUT_WIDTH) - sum_ones;
        all_zero  = &s1_zero;
        case (s1_mode)
            MODE_ONES:  result = sum_ones;
            MODE_ZEROS: result = sum_zeros;
            MODE_LZ:    result = sum_lz;
            default:    result = sum_tz;
        endcase
    end

    // Stage 2 / output registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            OutValid <= 1'b0;
            Count    <= '0;
            AllZero  <= 1'b0;
        end else if (s2_load) begin
            OutValid <= v1;
            if (v1) begin
                Count   <= result;
                AllZero <= all_zero;
            end
        end
    end

`ifdef BIT_COUNT_ACCUM_EN
    localparam int SUM_W = ((ACC_WIDTH > COUNT_WIDTH) ? ACC_WIDTH : COUNT_WIDTH) + 1;
    localparam logic [SUM_W-1:0] ACC_MAX = {{(SUM_W - ACC_WIDTH){1'b0}}, {ACC_WIDTH{1'b1}}};

    logic [SUM_W-1:0] acc_base;
    logic [SUM_W-1:0] acc_sum;
    logic             out_fire;

    assign out_fire = OutValid && OutReady;

    // Clear takes effect first, so a same-cycle transfer lands on zero.
    always_comb begin
        acc_base = AccClr ? '0 : SUM_W'(AccTotal);
        acc_sum  = acc_base;
        if (out_fire) begin
            acc_sum = acc_base + SUM_W'(Count);
        end
        if (acc_sum > ACC_MAX) begin
            acc_sum = ACC_MAX;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            AccTotal <= '0;
        end else if (AccClr || out_fire) begin
            AccTotal <= acc_sum[ACC_WIDTH-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_bit_count_pipe.sv
// Directed self-checking bench for bit_count_pipe (INPUT_WIDTH=10, CHUNK_WIDTH=4).
// Accumulator checks are included when BIT_COUNT_ACCUM_EN is defined.
module tb_bit_count_pipe;

    localparam int IW = 10;
    localparam int CW = 4;
    localparam int NW = 4;
    localparam int AW = 4;
    localparam int W  = NW + 1;

    logic          CLK;
    logic          nRST;
    logic          InValid;
    logic          InReady;
    logic [1:0]    Mode;
    logic [IW-1:0] Input;
    logic          OutValid;
    logic          OutReady;
    logic [NW-1:0] Count;
    logic          AllZero;
`ifdef BIT_COUNT_ACCUM_EN
    logic          AccClr;
    logic [AW-1:0] AccTotal;
`endif

    bit_count_pipe #(
        .INPUT_WIDTH (IW),
        .CHUNK_WIDTH (CW),
        .COUNT_WIDTH (NW),
        .ACC_WIDTH   (AW)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .InValid  (InValid),
        .InReady  (InReady),
        .Mode     (Mode),
        .Input    (Input),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Count    (Count),
`ifdef BIT_COUNT_ACCUM_EN
        .AccClr   (AccClr),
        .AccTotal (AccTotal),
`endif
        .AllZero  (AllZero)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // scoreboard: {AllZero, Count} per accepted word, in order
    logic [W-1:0] exp_q[$];
    int run_len   = 0;
    int max_run   = 0;
    int ready_low = 0;
    bit watch_rdy = 0;

    always @(negedge CLK) begin
        #3;
        if (OutValid) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
        if (watch_rdy && !InReady) ready_low++;
        if (OutValid && OutReady) begin
            check("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                check("sb_out", {AllZero, Count}, exp_q.pop_front());
            end
        end
    end

    // drivers
    task automatic send(input logic [IW-1:0] data, input logic [1:0] mode,
                        input logic [NW-1:0] cnt, input logic az);
        int   waits;
        logic acc;
        @(negedge CLK);
        InValid = 1'b1;
        Input   = data;
        Mode    = mode;
        waits   = 0;
        do begin
            #4;
            acc = InReady;
            @(posedge CLK);
            waits++;
        end while (!acc && waits < 200);
        check("send_accept", acc, 1);
        if (acc) exp_q.push_back({az, cnt});
    endtask

    task automatic idle();
        @(negedge CLK);
        InValid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        nRST     = 1'b0;
        InValid  = 1'b0;
        Input    = '0;
        Mode     = 2'b00;
        OutReady = 1'b1;
`ifdef BIT_COUNT_ACCUM_EN
        AccClr   = 1'b0;
`endif
        repeat (3) @(negedge CLK);
        check("rst_out_valid", OutValid, 0);
        check("rst_count", Count, 0);
        check("rst_all_zero", AllZero, 0);
        nRST = 1'b1;
        #1;
        check("rst_in_ready", InReady, 1);

        // first word: visible after the edge following the accept edge
        send(10'b1011001110, 2'b00, 4'd6, 1'b0);
        #1;
        InValid = 1'b0;
        check("lat_accept_edge", OutValid, 0);
        @(posedge CLK);
        #1;
        check("lat_next_edge", OutValid, 1);
        check("lat_count", Count, 6);
        drain();

        // directed vectors
        send(10'b1011001110, 2'b01, 4'd4, 1'b0);
        send(10'b0001000000, 2'b00, 4'd1, 1'b0);
        send(10'b0001000000, 2'b01, 4'd9, 1'b0);
        send(10'b0000000000, 2'b01, 4'd10, 1'b1);
        send(10'b0000000000, 2'b00, 4'd0, 1'b1);
        send(10'b0000000000, 2'b11, 4'd10, 1'b1);
        send(10'b1111111111, 2'b01, 4'd0, 1'b0);
        send(10'b1111111111, 2'b10, 4'd0, 1'b0);
        send(10'b1111111111, 2'b11, 4'd0, 1'b0);
        send(10'b0100000000, 2'b10, 4'd1, 1'b0);
        send(10'b0100000000, 2'b11, 4'd8, 1'b0);
        send(10'b0000010000, 2'b10, 4'd5, 1'b0);
        send(10'b0000010000, 2'b11, 4'd4, 1'b0);
        idle();
        drain();

        // 8 back-to-back words, mode changes between neighbours
        repeat (2) @(negedge CLK);
        max_run   = 0;
        ready_low = 0;
        watch_rdy = 1;
        send(10'b1011001110, 2'b00, 4'd6, 1'b0);
        send(10'b1011001110, 2'b01, 4'd4, 1'b0);
        send(10'b0001000000, 2'b10, 4'd3, 1'b0);
        send(10'b0001000000, 2'b11, 4'd6, 1'b0);
        send(10'b0000000000, 2'b10, 4'd10, 1'b1);
        send(10'b1111111111, 2'b00, 4'd10, 1'b0);
        send(10'b1000000000, 2'b11, 4'd9, 1'b0);
        send(10'b0000000001, 2'b10, 4'd9, 1'b0);
        idle();
        watch_rdy = 0;
        drain();
        repeat (2) @(negedge CLK);
        check("stream_out_run", max_run, 8);
        check("stream_ready_low", ready_low, 0);

        // backpressure: two words held, third waits
        @(negedge CLK);
        OutReady = 1'b0;
        send(10'b1011001110, 2'b00, 4'd6, 1'b0);
        send(10'b1111111111, 2'b10, 4'd0, 1'b0);
        @(negedge CLK);
        InValid = 1'b1;
        Input   = 10'b0000010000;
        Mode    = 2'b11;
        for (int i = 0; i < 5; i++) begin
            #4;
            check("stall_in_ready", InReady, 0);
            check("stall_out_valid", OutValid, 1);
            check("stall_count", Count, 6);
            @(negedge CLK);
        end
        InValid  = 1'b0;
        OutReady = 1'b1;
        send(10'b0000010000, 2'b11, 4'd4, 1'b0);
        idle();
        drain();

        // reset with both stages occupied
        OutReady = 1'b0;
        send(10'b1011001110, 2'b00, 4'd6, 1'b0);
        send(10'b0001000000, 2'b11, 4'd6, 1'b0);
        @(negedge CLK);
        InValid = 1'b0;
        nRST    = 1'b0;
        #1;
        check("midrst_out_valid", OutValid, 0);
        check("midrst_count", Count, 0);
        exp_q.delete();
        @(negedge CLK);
        nRST     = 1'b1;
        OutReady = 1'b1;
        send(10'b0001000000, 2'b10, 4'd3, 1'b0);
        idle();
        drain();

`ifdef BIT_COUNT_ACCUM_EN
        @(negedge CLK);
        AccClr = 1'b1;
        @(negedge CLK);
        AccClr = 1'b0;
        #1;
        check("acc_clear", AccTotal, 0);
        send(10'b1011001110, 2'b00, 4'd6, 1'b0);
        idle();
        drain();
        check("acc_6", AccTotal, 6);
        send(10'b1011001110, 2'b00, 4'd6, 1'b0);
        idle();
        drain();
        check("acc_12", AccTotal, 12);
        send(10'b1011001110, 2'b00, 4'd6, 1'b0);
        idle();
        drain();
        check("acc_sat", AccTotal, 15);
        OutReady = 1'b0;
        send(10'b1011001110, 2'b01, 4'd4, 1'b0);
        idle();
        @(negedge CLK);
        AccClr   = 1'b1;
        OutReady = 1'b1;
        @(negedge CLK);
        AccClr = 1'b0;
        #1;
        check("acc_clr_add", AccTotal, 4);
        drain();
`endif

        repeat (3) @(negedge CLK);
        check("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
